// File: rtl/window3x3_stream.sv
// Streaming 3x3 window generator: two line buffers plus tap columns, border padding,
// valid/ready input and iBusy output stall. Define WINDOW3X3_REPLICATE_PAD_EN for edge-replicate padding.
module window3x3_stream #(
  parameter int DATA_W = 8,
  parameter int CH     = 3,
  parameter int WIDTH  = 480,
  parameter int HEIGHT = 272
) (
  input  logic                         iClk,
  input  logic                         iRst,
  input  logic                         iStart,
  input  logic                         iValid,
  input  logic [CH*DATA_W-1:0]         iPixel,
  output logic                         oReady,
  output logic                         oValid,
  output logic [9*CH*DATA_W-1:0]       oWindow,
  output logic [$clog2(HEIGHT)-1:0]    oRow,
  output logic [$clog2(WIDTH)-1:0]     oCol,
  input  logic                         iBusy,
  output logic                         oFrameDone,
  output logic [2:0]                   oState
);
  localparam int PW = CH * DATA_W;
  localparam int RW = $clog2(HEIGHT);
  localparam int CW = $clog2(WIDTH);
  localparam int FW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LastCol   = CW'(WIDTH - 1);
  localparam logic [RW-1:0] LastRow   = RW'(HEIGHT - 1);
  localparam logic [FW-1:0] FlushLast = FW'(WIDTH);

  typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DONE} state_t;
  state_t state, stateNext;

  // Handshake: input beat when iValid && oReady; output consumed when oValid && !iBusy.
  // A pending output under iBusy freezes the whole pipeline.
  logic stall, accept, beat, produce, doneNext;
  logic [CW-1:0] inCol, cenCol;
  logic [RW-1:0] inRow, cenRow;
  logic [FW-1:0] flushCnt;
  logic [PW-1:0] beatPix;
  logic [PW-1:0] lb0 [WIDTH];
  logic [PW-1:0] lb1 [WIDTH];
  logic [PW-1:0] colL [3];
  logic [PW-1:0] colC [3];
  logic [PW-1:0] colN [3];
  logic [PW-1:0] win [9];
  logic [9*PW-1:0] winFlat;

  assign stall   = oValid && iBusy;
  assign oReady  = (state == FILL || state == RUN) && !stall;
  assign accept  = iValid && oReady;
  assign beat    = accept || (state == FLUSH && !stall);
  assign produce = beat && (state == RUN || state == FLUSH);
  assign beatPix = (state == FLUSH) ? '0 : iPixel;
  assign oState  = state;

  assign colN[0] = lb1[inCol];
  assign colN[1] = lb0[inCol];
  assign colN[2] = beatPix;

  always_ff @(posedge iClk) begin
    if (iRst) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    doneNext  = 1'b0;
    case (state)
      IDLE:  if (iStart) stateNext = FILL;
      FILL:  if (accept && inRow == RW'(1) && inCol == '0) stateNext = RUN;
      RUN:   if (accept && inRow == LastRow && inCol == LastCol) stateNext = FLUSH;
      FLUSH: if (beat && flushCnt == FlushLast) stateNext = DONE;
      DONE: begin
        if (!oValid || !iBusy) begin
          stateNext = IDLE;
          doneNext  = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Left/centre come from previous beats, right column is this beat; the mask is
  // what keeps the previous line's pixels out at a line wrap.
  always_comb begin
    for (int k = 0; k < 9; k++) win[k] = '0;
    for (int r = 0; r < 3; r++) begin
      win[3*r]   = colL[r];
      win[3*r+1] = colC[r];
      win[3*r+2] = colN[r];
    end
`ifdef WINDOW3X3_REPLICATE_PAD_EN
    for (int c = 0; c < 3; c++) begin
      if (cenRow == '0)     win[c]   = win[3+c];
      if (cenRow == LastRow) win[6+c] = win[3+c];
    end
    for (int r = 0; r < 3; r++) begin
      if (cenCol == '0)      win[3*r]   = win[3*r+1];
      if (cenCol == LastCol) win[3*r+2] = win[3*r+1];
    end
`else
    for (int c = 0; c < 3; c++) begin
      if (cenRow == '0)      win[c]     = '0;
      if (cenRow == LastRow) win[6+c]   = '0;
      if (cenCol == '0)      win[3*c]   = '0;
      if (cenCol == LastCol) win[3*c+2] = '0;
    end
`endif
    winFlat = '0;
    for (int k = 0; k < 9; k++) winFlat[k*PW +: PW] = win[k];
  end

  always_ff @(posedge iClk) begin
    if (beat) begin
      lb1[inCol] <= lb0[inCol];
      lb0[inCol] <= beatPix;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oValid     <= 1'b0;
      oWindow    <= '0;
      oRow       <= '0;
      oCol       <= '0;
      oFrameDone <= 1'b0;
      inCol      <= '0;
      inRow      <= '0;
      cenCol     <= '0;
      cenRow     <= '0;
      flushCnt   <= '0;
      for (int r = 0; r < 3; r++) begin
        colL[r] <= '0;
        colC[r] <= '0;
      end
    end else begin
      oFrameDone <= doneNext;
      if (state == IDLE && iStart) begin
        inCol    <= '0;
        inRow    <= '0;
        cenCol   <= '0;
        cenRow   <= '0;
        flushCnt <= '0;
      end
      if (beat) begin
        for (int r = 0; r < 3; r++) begin
          colL[r] <= colC[r];
          colC[r] <= colN[r];
        end
        if (inCol == LastCol) begin
          inCol <= '0;
          if (inRow != LastRow) inRow <= inRow + 1'b1;
        end else begin
          inCol <= inCol + 1'b1;
        end
        if (state == FLUSH) flushCnt <= flushCnt + 1'b1;
      end
      if (produce) begin
        oValid  <= 1'b1;
        oWindow <= winFlat;
        oRow    <= cenRow;
        oCol    <= cenCol;
        if (cenCol == LastCol) begin
          cenCol <= '0;
          cenRow <= (cenRow == LastRow) ? '0 : cenRow + 1'b1;
        end else begin
          cenCol <= cenCol + 1'b1;
        end
      end else if (oValid && !iBusy) begin
        oValid <= 1'b0;
      end
    end
  end
endmodule
